seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl.sv | 73 +++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit hex scan controller feeding the 7-segment decoder.
// Double-buffers the displayed value and optionally blanks leading zeros.
module seg7_scan_ctrl #(
  parameter int DIV = 4,
  parameter int PW  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blank_lz,
  output logic [3:0]  num,
  output logic [1:0]  numl_scan_select,
  output logic        digit_en,
  output logic        frame_done
);

  logic [PW-1:0] pre_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   active_reg;
  logic [15:0]   pending_reg;
  logic          pend_v_reg;

  logic tick;
  logic wrap;

  assign tick = (pre_reg == PW'(DIV - 1));
  assign wrap = tick && (idx_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg     <= '0;
      idx_reg     <= '0;
      active_reg  <= '0;
      pending_reg <= '0;
      pend_v_reg  <= 1'b0;
    end else begin
      if (tick) begin
        pre_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        pre_reg <= pre_reg + PW'(1);
      end

      // A load coinciding with the wrap still lets the old pending value through.
      if (wrap && pend_v_reg) begin
        active_reg <= pending_reg;
      end

      if (load) begin
        pending_reg <= data_in;
        pend_v_reg  <= 1'b1;
      end else if (wrap) begin
        pend_v_reg  <= 1'b0;
      end
    end
  end

  logic [3:0] nibbles [4];
  logic [3:0] upper_zero;

  // upper_zero[i]: every nibble at position i and above is zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign nibbles[gi]    = active_reg[4*gi+3 : 4*gi];
    assign upper_zero[gi] = (active_reg[15 : 4*gi] == '0);
  end

  assign num              = nibbles[idx_reg];
  assign numl_scan_select = idx_reg;
  assign digit_en         = !(blank_lz && (idx_reg != 2'd0) && upper_zero[idx_reg]);
  assign frame_done       = wrap;

endmodule
